// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a bank of common-anode 7-segment
//   digits that share one hex-to-segment decoder. The controller keeps a
//   frame-coherent copy of a DIGITS x 4-bit value and scans it one digit per
//   slot. Each slot begins with a guard interval where every anode is off, so
//   the nibble can change without ghosting.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous reset, active-high
//   load         in   one-cycle strobe, captures value into the shadow register
//   value        in   4*DIGITS bits, digit i = value[4i+3:4i], digit 0 rightmost
//   lz_en        in   leading-zero blanking enable
//   nibble       out  shared decoder inputs {A,B,C,D}
//   digit_en     out  anode enables, active-low, bit i = digit i
//   frame_start  out  one-cycle pulse at the start of every frame after the first
//   pending      out  shadow holds a value that is not displayed yet
module display_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000,
   parameter int GUARD  = 500
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   input  logic                lz_en,
   output logic [3:0]          nibble,
   output logic [DIGITS-1:0]   digit_en,
   output logic                frame_start,
   output logic                pending
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(DIGITS);

   typedef enum logic {S_GUARD, S_DRIVE} state_t;

   state_t              state;
   logic [DW-1:0]       div_cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] disp;

   logic slot_end;
   logic frame_end;

   assign slot_end  = (div_cnt == DW'(DIV - 1));
   assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt     <= '0;
         idx         <= '0;
         state       <= S_GUARD;
         shadow      <= '0;
         disp        <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
         if (slot_end)
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

         // Slots always end in DRIVE and restart in GUARD, so idx only
         // changes while every anode is off.
         case (state)
            S_GUARD: if (div_cnt == DW'(GUARD - 1)) state <= S_DRIVE;
            S_DRIVE: if (slot_end)                  state <= S_GUARD;
            default:                                state <= S_GUARD;
         endcase

         frame_start <= frame_end;

         if (load)
            shadow <= value;

         // disp only changes on the frame boundary so a frame never mixes old
         // and new digits. A load in the boundary cycle bypasses shadow.
         if (frame_end) begin
            if (pending || load)
               disp <= load ? value : shadow;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   assign nibble = disp[4*idx +: 4];

   // Walk from the most significant digit down; tail_zero tracks whether
   // this digit and everything above it are zero in the displayed value.
   logic tail_zero;
   logic blank;

   always_comb begin
      tail_zero = 1'b1;
      blank     = 1'b0;
      digit_en  = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         tail_zero = tail_zero && (disp[4*i +: 4] == 4'd0);
         blank     = lz_en && (i > 0) && tail_zero;
         if ((state == S_DRIVE) && (idx == IW'(i)) && !blank)
            digit_en[i] = 1'b0;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl (DIGITS=4, DIV=8, GUARD=2).
// A reference model tracks time since reset and the displayed/shadow values
// and pushes a snapshot per cycle; a monitor pops each snapshot on the
// falling edge and compares the DUT outputs against it.
module tb_display_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int DIV    = 8;
   localparam int GUARD  = 2;
   localparam int FRAME  = DIGITS * DIV;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load  = 1'b0;
   logic        lz_en = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  nibble;
   logic [3:0]  digit_en;
   logic        frame_start;
   logic        pending;

   display_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
      .clock       (clock),
      .reset       (reset),
      .load        (load),
      .value       (value),
      .lz_en       (lz_en),
      .nibble      (nibble),
      .digit_en    (digit_en),
      .frame_start (frame_start),
      .pending     (pending)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] disp;
      int          t;
      bit          pend;
      bit          fs;
   } snap_t;

   snap_t sbq[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   // ---------------- reference model ----------------
   logic [15:0] m_disp   = 16'h0;
   logic [15:0] m_shadow = 16'h0;
   bit          m_pend   = 1'b0;
   bit          m_fs     = 1'b0;
   int          m_t      = 0;   // cycles since reset release

   always @(posedge clock) begin
      if (reset) begin
         m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0; m_fs = 1'b0; m_t = 0;
      end else begin
         if ((m_t % FRAME) == FRAME - 1) begin
            if (m_pend || load) m_disp = load ? value : m_shadow;
            m_pend = 1'b0;
            m_fs   = 1'b1;
         end else begin
            m_fs = 1'b0;
            if (load) m_pend = 1'b1;
         end
         if (load) m_shadow = value;
         m_t++;
      end
      sbq.push_back('{m_disp, m_t, m_pend, m_fs});
   end

   // ---------------- monitor ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp, input int t);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
      end
   endtask

   snap_t      s;
   int         slot, pos;
   logic [3:0] exp_nib, exp_en;
   bit         blank;

   always @(negedge clock) begin
      if (sbq.size() > 0) begin
         s       = sbq.pop_front();
         slot    = (s.t / DIV) % DIGITS;
         pos     = s.t % DIV;
         exp_nib = s.disp[4*slot +: 4];
         blank   = lz_en && (slot > 0) && ((s.disp >> (4*slot)) == 16'd0);
         exp_en  = (pos >= GUARD && !blank) ? ~(4'b0001 << slot) : 4'hF;
         check("nibble",      {12'h0, nibble},      {12'h0, exp_nib}, s.t);
         check("digit_en",    {12'h0, digit_en},    {12'h0, exp_en},  s.t);
         check("pending",     {15'h0, pending},     {15'h0, s.pend},  s.t);
         check("frame_start", {15'h0, frame_start}, {15'h0, s.fs},    s.t);
         check("one_anode",   {15'h0, ($countones(~digit_en) <= 1)}, 16'h1, s.t);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Advance until the current cycle sits at frame position fpos.
   task automatic go_to(input int fpos);
      int k = 0;
      while ((m_t % FRAME) != fpos && k < 2 * FRAME) begin
         cyc(1);
         k++;
      end
      n_chk++;
      if ((m_t % FRAME) != fpos) begin
         n_fail++;
         $display("FAIL go_to got=%0d want=%0d", m_t % FRAME, fpos);
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load  = 1'b1;
      value = v;
      cyc(1);
      load  = 1'b0;
   endtask

   initial begin
      // reset, run partway into a frame, reset again mid-scan
      reset = 1'b1; cyc(3);
      reset = 1'b0; cyc(13);
      reset = 1'b1; cyc(3);
      reset = 1'b0;

      // basic scan
      go_to(5);  do_load(16'h1234);
      cyc(2 * FRAME);

      // frame coherence: two loads in one frame, last wins
      go_to(1 * DIV + 3); do_load(16'hABCD);
      go_to(2 * DIV + 3); do_load(16'h5678);
      go_to(0);           cyc(FRAME + 2);

      // load exactly in the boundary cycle
      go_to(FRAME - 1); do_load(16'h00F0);
      cyc(FRAME + 2);

      // leading-zero blanking
      lz_en = 1'b1;
      go_to(3); do_load(16'h0070);
      cyc(2 * FRAME);
      do_load(16'h0000);
      cyc(2 * FRAME);
      lz_en = 1'b0;
      cyc(FRAME);

      // randomized traffic, with occasional resets
      repeat (600) begin
         load  = ($urandom_range(0, 7) == 0);
         value = 16'($urandom);
         if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
         if ($urandom_range(0, 3) == 0)  value[15:8] = 8'h00;
         reset = ($urandom_range(0, 199) == 0);
         cyc(1);
      end
      reset = 1'b0; load = 1'b0;
      cyc(FRAME + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one hex-to-segment decoder. It holds a frame-coherent copy of a DIGITS×4-bit value and steps through the digits. For each digit it drives that digit's nibble onto the shared decoder's A,B,C,D inputs and enables only that digit's anode. A guard interval at the start of every slot keeps all anodes off, which prevents ghosting while the nibble changes.

## Interface
- DIGITS, default 4: number of multiplexed digits (2..8).
- DIV, default 50000: clock cycles per digit slot; requires DIV ≥ GUARD+2.
- GUARD, default 500: cycles at the start of each slot with all anodes off; requires GUARD ≥ 1.
- clock  in  1  Single clock domain, rising edge.
- reset  in  1  Synchronous reset, active-high.
- load  in  1  Single-cycle strobe; captures value into the shadow register.
- value  in  4*DIGITS  Digit i is value[4i+3:4i]; digit 0 is rightmost.
- lz_en  in  1  Leading-zero blanking enable.
- nibble  out  4  To the decoder inputs {A,B,C,D} = nibble[3:0].
- digit_en  out  DIGITS  Anode enables, active-low; bit i selects digit i.
- frame_start  out  1  One-cycle pulse at the start of every frame after the first.
- pending  out  1  High while the shadow register holds a value not yet displayed.

## Operation
- **Registers**
  - div_cnt counts 0..DIV-1.
  - idx counts 0..DIGITS-1.
  - state is GUARD or DRIVE.
  - shadow and disp are each 4*DIGITS bits.
  - pending and frame_start are 1 bit each.
- **Reset values:** div_cnt=0, idx=0, state=GUARD, shadow=0, disp=0, pending=0, frame_start=0. The outputs therefore reset to digit_en all ones (all digits off) and nibble=0.
- **Counter:** div_cnt increments every cycle. At DIV-1 it wraps to 0 and idx increments. idx wraps from DIGITS-1 to 0.
- **State machine:**
  - GUARD→DRIVE when div_cnt==GUARD-1.
  - DRIVE→GUARD when div_cnt==DIV-1.
  - There are no other transitions.
- **Frame boundary:** the cycle in which div_cnt==DIV-1 and idx==DIGITS-1. At that clock edge:
  - disp ← (load ? value : shadow) if (pending or load); otherwise disp is unchanged.
  - pending ← 0.
  - frame_start ← 1.
- **frame_start:** registered; 0 in every other cycle.
- **load outside the boundary:** shadow ← value and pending ← 1. A repeated load before the boundary overwrites shadow; the last one wins.
- **load in the boundary cycle:** value goes straight to disp. shadow also ← value, and pending ends 0.
- **nibble:** combinational, equal to disp[4·idx+3:4·idx]. It is valid for the entire slot, including GUARD.
- **digit_en[i]:** combinational. It is 0 only when state==DRIVE, idx==i, and digit i is not blanked; otherwise 1.
- **Blanked digit:** digit i is blanked when lz_en=1, i>0, and disp nibbles i..DIGITS-1 are all 0. Digit 0 is never blanked. Blanking is evaluated on disp, not on shadow.
- **Reset mid-frame:** restarts at slot 0 in GUARD and discards both disp and the pending shadow.

## Timing
- **Frame period:** DIGITS·DIV cycles.
- **Slot layout:** each slot has GUARD cycles with the anode off, then DIV-GUARD cycles with the anode on.
- **At most one digit_en bit is low in any cycle.** Every idx change occurs while all anodes are off: the slot ends in DRIVE at div_cnt=DIV-1, then the next slot starts in GUARD.
- **Load-to-display latency:** from the load edge to the first cycle in which the new value is visible on nibble for slot 0 is between 1 and DIGITS·DIV cycles. It is never mid-frame, so a frame never mixes old and new digits.
- **frame_start:** high in the first cycle of each frame, i.e. idx=0, div_cnt=0.
- **First frame after reset:** frame_start does not pulse.

## Test plan
All scenarios use DIGITS=4, DIV=8, GUARD=2.
- **Reset:** assert reset for 3 cycles mid-scan.
  - Next cycle: digit_en=4'b1111, nibble=0, pending=0, div_cnt=0.
  - digit_en[0] goes low at cycle 2 after release.
- **Scan:** load value=16'h1234 during the first frame, then run 2 frames.
  - Second frame: nibble sequence 4,3,2,1 with 8 cycles each.
  - digit_en lows are 1110, 1101, 1011, 0111, each for 6 cycles, preceded by 2 cycles of 1111.
- **Frame coherence:** in the first frame, load 16'hABCD at idx=1 and load 16'h5678 at idx=2.
  - pending=1 until the boundary.
  - The next frame shows only 8,7,6,5; neither ABCD nor any mix appears.
- **Boundary load:** load 16'h00F0 exactly in the boundary cycle.
  - The next frame shows 0,F,0,0.
  - pending stays 0.
  - frame_start pulses once.
- **Leading-zero blanking:** lz_en=1, value=16'h0070.
  - Digits 0 and 1 are enabled.
  - digit_en[3:2] stays 11 all frame.
  - With value=16'h0000, only digit 0 lights and shows 0.
- **Invariant checker (run on all tests):**
  - popcount(~digit_en) ≤ 1.
  - digit_en is all ones in every cycle where div_cnt < GUARD.
